aes_sbox_scheduler: RTL and testbench
=====================================

# aes_sbox_scheduler

Shares the single byte-wide S-box ROM between two requesters: the round datapath (16-byte SubBytes) and the key schedule (4-byte SubWord). It arbitrates round-robin, serialises the granted operand one byte per cycle into the ROM, tracks bytes in flight across the ROM latency, and reassembles the substituted result. It sits between the round/key-expansion control and the byte-serial FIFO/ROM path of the AES-256 core.

## Interface
Parameters:
- ROM_LAT, 1, cycles from rom_addr/rom_en to valid rom_data (legal 1..3)

Ports (reset resetn, synchronous, active-low; clock clk):
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- dp_req  in  1  datapath request, level, held until dp_gnt
- dp_state  in  128  datapath operand, byte 0 = [127:120]
- dp_gnt  out  1  one-cycle pulse, operand captured
- dp_done  out  1  one-cycle pulse, dp_result valid
- dp_result  out  128  substituted state, held until next dp job completes
- ks_req  in  1  key-schedule request, level, held until ks_gnt
- ks_word  in  32  key-schedule operand, byte 0 = [31:24]
- ks_gnt  out  1  one-cycle pulse
- ks_done  out  1  one-cycle pulse, ks_result valid
- ks_result  out  32  substituted word, held
- rom_en  out  1  ROM read strobe
- rom_addr  out  8  ROM address (operand byte)
- rom_data  in  8  ROM output
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: if exactly one req is high, grant it; if both, grant the one not served last. last_served resets to KS, so DP wins the first tie.
- Grant at edge E: operand captured into a shift register, N = 16 (DP) or 4 (KS), byte index cleared, state -> RUN.
- RUN: each cycle rom_en=1, rom_addr=operand byte idx, idx++. After byte N-1 is issued, go to DRAIN.
- Tag pipe: ROM_LAT-deep shift of {valid, idx}. When the tag emerges valid, rom_data is written into result lane idx of the active requester's result register.
- DRAIN: rom_en=0. When the last tag has been written, pulse the active done signal, update last_served, go to IDLE.
- rom_data is ignored whenever no valid tag emerges.
- req sampled only in IDLE. req still high after done is a new job.
- Reset mid-operation: job aborted, tag pipe cleared, no done pulse, last_served=KS. In-flight ROM data is discarded.
- Reset values: every output 0, including dp_result and ks_result. State IDLE.

## Timing
- Let G be the cycle in which gnt is high. rom_en is high in cycles G..G+N-1, with rom_addr = byte i in cycle G+i.
- Byte i data is valid in cycle G+i+ROM_LAT.
- done is high in cycle G+N+ROM_LAT, with the result register already updated in that cycle.
- ROM_LAT=1: DP done = G+17, KS done = G+5.
- The done cycle is IDLE, so a pending request gets its gnt in the cycle after done. No overlap between jobs; ROM throughput during RUN is 1 byte/cycle.
- gnt and done are never high in the same cycle.
- busy covers G..G+N+ROM_LAT-1.

## Structure
- Package aes_pkg holds:
  - typedef enum sched_state_t {IDLE, RUN, DRAIN}
  - typedef enum req_id_t {REQ_DP, REQ_KS}
  - localparams DP_BYTES=16, KS_BYTES=4
- Sub-module aes_sbox_tagpipe (parameter ROM_LAT) carries {valid, 4-bit idx} and outputs the emerging tag.
- All results, operand shift, arbitration and FSM stay in the top level.

## Test plan
- ROM_LAT=1, DP job on 00102030405060708090a0b0c0d0e0f0:
  - dp_result = 63cab7040953d051cd60e0e7ba70e18c
  - dp_done at G+17
  - rom_en high for exactly 16 cycles
- KS job on 00000000: ks_result = 63636363, ks_done at G+5, dp outputs unchanged.
- dp_req and ks_req both rise together after reset:
  - dp_gnt first, ks_gnt in cycle dp_done+1
  - ks_done 5 cycles after ks_gnt
- Both requests held high for 4 jobs: grants alternate DP, KS, DP, KS with no idle gap beyond the done cycle.
- resetn low for one cycle during DP RUN at idx 7:
  - next cycle all outputs 0, no dp_done
  - a following DP job returns correct data
- ROM_LAT=3, KS job on 01020304: ks_result = 7c777bf2, ks_done at G+7.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the S-box scheduler: FSM states, requester ids, job sizes.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
  typedef enum logic {REQ_DP, REQ_KS} req_id_t;
  localparam int DP_BYTES = 16;
  localparam int KS_BYTES = 4;
endpackage

// File: rtl/aes_sbox_tagpipe.sv
// Delays {valid, byte index} by ROM_LAT cycles so each tag meets its rom_data.
module aes_sbox_tagpipe #(
  parameter int ROM_LAT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_vld,
  input  logic [3:0] in_idx,
  output logic       out_vld,
  output logic [3:0] out_idx
);
  logic [ROM_LAT:1]      vld_pipe_q, vld_pipe_d;
  logic [ROM_LAT:1][3:0] idx_pipe_q, idx_pipe_d;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    idx_pipe_d    = idx_pipe_q;
    vld_pipe_d[1] = in_vld;
    idx_pipe_d[1] = in_idx;
    for (int i = 2; i <= ROM_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      idx_pipe_d[i] = idx_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

  assign out_vld = vld_pipe_q[ROM_LAT];
  assign out_idx = idx_pipe_q[ROM_LAT];
endmodule

// File: rtl/aes_sbox_scheduler.sv
// Round-robin sharing of one byte-serial S-box ROM between the round datapath
// (16-byte SubBytes) and the key schedule (4-byte SubWord).
module aes_sbox_scheduler
  import aes_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         dp_req,
  input  logic [127:0] dp_state,
  output logic         dp_gnt,
  output logic         dp_done,
  output logic [127:0] dp_result,
  input  logic         ks_req,
  input  logic [31:0]  ks_word,
  output logic         ks_gnt,
  output logic         ks_done,
  output logic [31:0]  ks_result,
  output logic         rom_en,
  output logic [7:0]   rom_addr,
  input  logic [7:0]   rom_data,
  output logic         busy
);
  sched_state_t     state_q, state_d;
  req_id_t          act_q, act_d, last_q, last_d;
  logic [3:0]       idx_q, idx_d;
  logic [127:0]     opnd_q, opnd_d;
  logic             rom_en_q, rom_en_d;
  logic             dp_gnt_q, dp_gnt_d, ks_gnt_q, ks_gnt_d;
  logic             dp_done_q, dp_done_d, ks_done_q, ks_done_d;
  logic [15:0][7:0] dp_res_q, dp_res_d;
  logic [3:0][7:0]  ks_res_q, ks_res_d;
  logic             tag_vld;
  logic [3:0]       tag_idx;
  logic [3:0]       last_idx;

  aes_sbox_tagpipe #(.ROM_LAT(ROM_LAT)) u_tagpipe (
    .clk     (clk),
    .resetn  (resetn),
    .in_vld  (rom_en_q),
    .in_idx  (idx_q),
    .out_vld (tag_vld),
    .out_idx (tag_idx)
  );

  assign last_idx = (act_q == REQ_DP) ? 4'(DP_BYTES - 1) : 4'(KS_BYTES - 1);

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    last_d    = last_q;
    idx_d     = idx_q;
    opnd_d    = opnd_q;
    rom_en_d  = rom_en_q;
    dp_res_d  = dp_res_q;
    ks_res_d  = ks_res_q;
    dp_gnt_d  = 1'b0;
    ks_gnt_d  = 1'b0;
    dp_done_d = 1'b0;
    ks_done_d = 1'b0;

    // Byte 0 sits in the most significant lane of both result registers.
    if (tag_vld) begin
      if (act_q == REQ_DP) dp_res_d[4'd15 - tag_idx]      = rom_data;
      else                 ks_res_d[2'd3 - tag_idx[1:0]] = rom_data;
    end

    case (state_q)
      IDLE: begin
        if (dp_req && (!ks_req || last_q == REQ_KS)) begin
          act_d    = REQ_DP;
          opnd_d   = dp_state;
          dp_gnt_d = 1'b1;
          idx_d    = '0;
          rom_en_d = 1'b1;
          state_d  = RUN;
        end else if (ks_req) begin
          act_d    = REQ_KS;
          opnd_d   = {ks_word, 96'b0};
          ks_gnt_d = 1'b1;
          idx_d    = '0;
          rom_en_d = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        opnd_d = {opnd_q[119:0], 8'h00};
        idx_d  = idx_q + 4'd1;
        if (idx_q == last_idx) begin
          rom_en_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_vld && tag_idx == last_idx) begin
          dp_done_d = (act_q == REQ_DP);
          ks_done_d = (act_q == REQ_KS);
          last_d    = act_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      act_q     <= REQ_DP;
      last_q    <= REQ_KS;
      idx_q     <= '0;
      opnd_q    <= '0;
      rom_en_q  <= 1'b0;
      dp_gnt_q  <= 1'b0;
      ks_gnt_q  <= 1'b0;
      dp_done_q <= 1'b0;
      ks_done_q <= 1'b0;
      dp_res_q  <= '0;
      ks_res_q  <= '0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      opnd_q    <= opnd_d;
      rom_en_q  <= rom_en_d;
      dp_gnt_q  <= dp_gnt_d;
      ks_gnt_q  <= ks_gnt_d;
      dp_done_q <= dp_done_d;
      ks_done_q <= ks_done_d;
      dp_res_q  <= dp_res_d;
      ks_res_q  <= ks_res_d;
    end
  end

  assign dp_gnt    = dp_gnt_q;
  assign ks_gnt    = ks_gnt_q;
  assign dp_done   = dp_done_q;
  assign ks_done   = ks_done_q;
  assign dp_result = dp_res_q;
  assign ks_result = ks_res_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = opnd_q[127:120];
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Directed bench: two schedulers (ROM_LAT 1 and 3) each fed by an S-box ROM model.
module tb_aes_sbox_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [0:255][7:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic dp_req1 = 0, ks_req1 = 0, dp_req3 = 0, ks_req3 = 0;
  logic [127:0] dp_state1 = '0, dp_state3 = '0;
  logic [31:0]  ks_word1 = '0, ks_word3 = '0;
  logic dp_gnt1, dp_done1, ks_gnt1, ks_done1, rom_en1, busy1;
  logic dp_gnt3, dp_done3, ks_gnt3, ks_done3, rom_en3, busy3;
  logic [127:0] dp_result1, dp_result3;
  logic [31:0]  ks_result1, ks_result3;
  logic [7:0]   rom_addr1, rom_addr3, rom_data3;
  logic [7:0]   rom_data1 = 8'hA5;

  aes_sbox_scheduler #(.ROM_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .dp_req(dp_req1), .dp_state(dp_state1), .dp_gnt(dp_gnt1),
    .dp_done(dp_done1), .dp_result(dp_result1), .ks_req(ks_req1), .ks_word(ks_word1),
    .ks_gnt(ks_gnt1), .ks_done(ks_done1), .ks_result(ks_result1), .rom_en(rom_en1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1));

  aes_sbox_scheduler #(.ROM_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .dp_req(dp_req3), .dp_state(dp_state3), .dp_gnt(dp_gnt3),
    .dp_done(dp_done3), .dp_result(dp_result3), .ks_req(ks_req3), .ks_word(ks_word3),
    .ks_gnt(ks_gnt3), .ks_done(ks_done3), .ks_result(ks_result3), .rom_en(rom_en3),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .busy(busy3));

  // ROM models; idle cycles return junk that the scheduler must ignore.
  always @(posedge clk) rom_data1 <= rom_en1 ? sbox_tbl[rom_addr1] : 8'hA5;
  logic [2:0]      en3p = '0;
  logic [2:0][7:0] ad3p = '0;
  always @(posedge clk) begin
    en3p <= {en3p[1:0], rom_en3};
    ad3p <= {ad3p[1:0], rom_addr3};
  end
  assign rom_data3 = en3p[2] ? sbox_tbl[ad3p[2]] : 8'h5A;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic cur_gnt(input bit s3, input bit ks);
    return s3 ? (ks ? ks_gnt3 : dp_gnt3) : (ks ? ks_gnt1 : dp_gnt1);
  endfunction
  function automatic logic cur_done(input bit s3, input bit ks);
    return s3 ? (ks ? ks_done3 : dp_done3) : (ks ? ks_done1 : dp_done1);
  endfunction
  function automatic logic [127:0] cur_res(input bit s3, input bit ks);
    if (ks) return 128'(s3 ? ks_result3 : ks_result1);
    return s3 ? dp_result3 : dp_result1;
  endfunction

  task automatic run_job(input bit s3, input bit ks, input logic [127:0] din,
                         input logic [31:0] kin, input logic [127:0] exp, input string nm);
    int g, d, en_cnt, lat, nb;
    bit got;
    logic [127:0] other_old;
    lat = s3 ? 3 : 1;
    nb  = ks ? 4 : 16;
    other_old = cur_res(s3, !ks);
    @(negedge clk);
    if (s3) begin dp_state3 = din; ks_word3 = kin; dp_req3 = !ks; ks_req3 = ks; end
    else    begin dp_state1 = din; ks_word1 = kin; dp_req1 = !ks; ks_req1 = ks; end
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (cur_gnt(s3, ks)) got = 1;
    end
    dp_req1 = 0; ks_req1 = 0; dp_req3 = 0; ks_req3 = 0;
    chk({nm, " gnt"}, 128'(got), 128'(1));
    if (!got) return;
    g = cyc;
    en_cnt = (s3 ? rom_en3 : rom_en1) ? 1 : 0;
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (s3 ? rom_en3 : rom_en1) en_cnt++;
      if (cur_done(s3, ks)) got = 1;
    end
    d = cyc;
    chk({nm, " done_latency"}, 128'(got ? d - g : -1), 128'(nb + lat));
    chk({nm, " rom_en_cycles"}, 128'(en_cnt), 128'(nb));
    chk({nm, " result"}, cur_res(s3, ks), exp);
    chk({nm, " other_unchanged"}, cur_res(s3, !ks), other_old);
  endtask

  typedef struct {
    bit           s3;
    bit           ks;
    logic [127:0] din;
    logic [31:0]  kin;
    logic [127:0] exp;
  } vec_t;
  vec_t vt[6];

  initial begin
    int dg, dd, kg, kd, n, ndone, g;
    bit overlap;
    bit gk[4];
    int gc[4];

    vt[0] = '{0, 0, 128'h00102030405060708090a0b0c0d0e0f0, 32'h0, 128'h63cab7040953d051cd60e0e7ba70e18c};
    vt[1] = '{0, 1, 128'h0, 32'h00000000, 128'h63636363};
    vt[2] = '{0, 0, 128'h000102030405060708090a0b0c0d0e0f, 32'h0, 128'h637c777bf26b6fc53001672bfed7ab76};
    vt[3] = '{0, 1, 128'h0, 32'h53ff0110, 128'hed167cca};
    vt[4] = '{1, 1, 128'h0, 32'h01020304, 128'h7c777bf2};
    vt[5] = '{1, 0, 128'h00102030405060708090a0b0c0d0e0f0, 32'h0, 128'h63cab7040953d051cd60e0e7ba70e18c};

    // Reset state
    resetn = 0;
    repeat (3) @(negedge clk);
    chk("rst1_dp_result", dp_result1, 128'h0);
    chk("rst1_ctl", 128'({dp_gnt1, dp_done1, ks_gnt1, ks_done1, ks_result1, rom_en1, rom_addr1, busy1}), 128'h0);
    chk("rst3_ctl", 128'({dp_gnt3, dp_done3, ks_gnt3, ks_done3, ks_result3, rom_en3, rom_addr3, busy3}), 128'h0);
    resetn = 1;

    // Simultaneous requests right after reset: DP wins, KS follows its done
    @(negedge clk);
    dp_state1 = vt[0].din; ks_word1 = 32'h01020304;
    dp_req1 = 1; ks_req1 = 1;
    dg = -1; dd = -1; kg = -1; kd = -1; overlap = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (dp_gnt1 && dg < 0) begin dg = cyc; dp_req1 = 0; end
      if (ks_gnt1 && kg < 0) begin kg = cyc; ks_req1 = 0; end
      if (dp_done1 && dd < 0) dd = cyc;
      if (ks_done1 && kd < 0) kd = cyc;
      if ((dp_gnt1 || ks_gnt1) && (dp_done1 || ks_done1)) overlap = 1;
    end
    dp_req1 = 0; ks_req1 = 0;
    chk("tie_dp_first", 128'(dg >= 0 && (kg < 0 || dg < kg)), 128'(1));
    chk("tie_dp_done", 128'(dd - dg), 128'(17));
    chk("tie_ks_gnt_after_done", 128'(kg - dd), 128'(1));
    chk("tie_ks_done", 128'(kd - kg), 128'(5));
    chk("tie_no_gnt_done_overlap", 128'(overlap), 128'(0));
    chk("tie_dp_result", dp_result1, vt[0].exp);
    chk("tie_ks_result", 128'(ks_result1), 128'h7c777bf2);

    // Both held high: grants alternate with only the done cycle between jobs
    @(negedge clk);
    dp_state1 = vt[2].din; ks_word1 = 32'h53ff0110;
    dp_req1 = 1; ks_req1 = 1;
    n = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if ((dp_gnt1 || ks_gnt1) && n < 4) begin
        gk[n] = ks_gnt1; gc[n] = cyc; n++;
        if (n == 4) begin dp_req1 = 0; ks_req1 = 0; end
      end
    end
    dp_req1 = 0; ks_req1 = 0;
    chk("alt_count", 128'(n), 128'(4));
    if (n == 4) begin
      chk("alt_order", 128'({gk[0], gk[1], gk[2], gk[3]}), 128'(4'b0101));
      chk("alt_gap01", 128'(gc[1] - gc[0]), 128'(18));
      chk("alt_gap12", 128'(gc[2] - gc[1]), 128'(6));
      chk("alt_gap23", 128'(gc[3] - gc[2]), 128'(18));
    end
    chk("alt_dp_result", dp_result1, vt[2].exp);
    chk("alt_ks_result", 128'(ks_result1), 128'hed167cca);

    // Table of single jobs
    foreach (vt[i])
      run_job(vt[i].s3, vt[i].ks, vt[i].din, vt[i].kin, vt[i].exp, $sformatf("vec%0d", i));

    // Reset while DP is issuing byte 7
    @(negedge clk);
    dp_state1 = vt[0].din; dp_req1 = 1;
    g = -1;
    for (int t = 0; t < 10 && g < 0; t++) begin
      @(negedge clk);
      if (dp_gnt1) g = cyc;
    end
    dp_req1 = 0;
    chk("abort_gnt", 128'(g >= 0), 128'(1));
    repeat (7) @(negedge clk);
    chk("abort_addr_idx7", 128'(rom_addr1), 128'h70);
    resetn = 0;
    @(negedge clk);
    chk("abort_dp_result", dp_result1, 128'h0);
    chk("abort_ctl", 128'({dp_gnt1, dp_done1, ks_gnt1, ks_done1, ks_result1, rom_en1, rom_addr1, busy1}), 128'h0);
    resetn = 1;
    ndone = 0;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (dp_done1) ndone++;
    end
    chk("abort_no_done", 128'(ndone), 128'(0));
    run_job(0, 0, vt[0].din, 32'h0, vt[0].exp, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
